cmn_reg_slice_backward_n: RTL and testbench

//  Parametrised successor of the common backward register slice: breaks the m_rdy->s_rdy timing path

---
 rtl/cmn_reg_slice_backward_n_pkg.sv | 22 ++
 rtl/cmn_reg_slice_backward_n_if.sv | 33 +++
 rtl/cmn_reg_slice_backward_n_store.sv | 31 +++
 rtl/cmn_reg_slice_backward_n.sv | 102 ++++++++++
 tb/tb_cmn_reg_slice_backward_n.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cmn_reg_slice_backward_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmn_reg_slice_pkg
// Description : Shared helpers for the backward register slice (pointer wrap).
// Revision    : 1.0 - initial release
// ============================================================================
package cmn_reg_slice_pkg;

    // Widest pointer needed for the largest supported depth (16 entries)
    localparam int PTR_MAX_W = 4;

    // Advance a buffer pointer, wrapping depth-1 -> 0 for any depth (pow2 or not)
    function automatic logic [PTR_MAX_W-1:0] ptr_inc(input logic [PTR_MAX_W-1:0] ptr,
                                                     input int                   depth);
        if (ptr == PTR_MAX_W'(depth - 1))
            return '0;
        else
            return ptr + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmn_reg_slice_backward_n_if.sv
`default_nettype none
// ============================================================================
// Module      : cmn_reg_slice_backward_n_if
// Description : Upstream/downstream valid-ready-payload bundle plus occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
interface cmn_reg_slice_backward_n_if #(
    parameter type PLD_TYPE = logic,
    parameter int  DEPTH    = 2
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             s_vld;
    logic             s_rdy;
    PLD_TYPE          s_pld;
    logic             m_vld;
    logic             m_rdy;
    PLD_TYPE          m_pld;
    logic [LVL_W-1:0] level;

    // master: the surrounding pipeline; slave: the register slice itself
    modport master (
        output s_vld, s_pld, m_rdy,
        input  s_rdy, m_vld, m_pld, level
    );

    modport slave (
        input  s_vld, s_pld, m_rdy,
        output s_rdy, m_vld, m_pld, level
    );

endinterface
`default_nettype wire

// File: rtl/cmn_reg_slice_backward_n_store.sv
`default_nettype none
// ============================================================================
// Module      : cmn_reg_slice_store
// Description : DEPTH-entry payload flop array, one write port, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module cmn_reg_slice_store #(
    parameter type PLD_TYPE = logic,
    parameter int  DEPTH    = 2,
    parameter int  PTR_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  PLD_TYPE          wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output PLD_TYPE          rd_data
);

    PLD_TYPE r_mem [DEPTH];

    // Data storage carries no reset; control guarantees stale entries are never presented
    always_ff @(posedge clk) begin
        if (wr_en)
            r_mem[wr_ptr] <= wr_data;
    end

    assign rd_data = r_mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/cmn_reg_slice_backward_n.sv
`default_nettype none
// ============================================================================
// Module      : cmn_reg_slice_backward_n
// Description : Backward register slice with DEPTH-entry buffer, registered
//               s_rdy, optional empty-bypass, synchronous flush and level.
// Revision    : 1.0 - initial release
// ============================================================================
module cmn_reg_slice_backward_n
    import cmn_reg_slice_pkg::*;
#(
    parameter type PLD_TYPE = logic,
    parameter int  DEPTH    = 2,
    parameter int  BYPASS   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    cmn_reg_slice_backward_n_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_s_rdy;

    logic [CNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0] w_wr_ptr_inc;
    logic [PTR_W-1:0] w_rd_ptr_inc;
    logic             w_byp_en;
    logic             w_empty;
    logic             w_s_fire;
    logic             w_m_vld;
    logic             w_m_fire;
    logic             w_byp;
    logic             w_push;
    logic             w_pop;
    PLD_TYPE          w_rd_data;

    if (BYPASS != 0) begin : g_bypass
        assign w_byp_en = 1'b1;
    end else begin : g_buffered
        assign w_byp_en = 1'b0;
    end

    assign w_empty  = (r_count == '0);
    assign w_s_fire = bus.s_vld & r_s_rdy;
    // A flush cycle hides everything downstream; a beat accepted then is dropped
    assign w_m_vld  = ~flush & (~w_empty | (w_byp_en & w_s_fire));
    assign w_m_fire = w_m_vld & bus.m_rdy;
    assign w_byp    = w_byp_en & w_empty & w_s_fire & bus.m_rdy;
    assign w_push   = w_s_fire & ~w_byp;
    assign w_pop    = w_m_fire & ~w_empty;

    assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_wr_ptr_inc = PTR_W'(ptr_inc(PTR_MAX_W'(r_wr_ptr), DEPTH));
    assign w_rd_ptr_inc = PTR_W'(ptr_inc(PTR_MAX_W'(r_rd_ptr), DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_s_rdy  <= 1'b0;
        end else if (flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_s_rdy  <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            if (w_push)
                r_wr_ptr <= w_wr_ptr_inc;
            if (w_pop)
                r_rd_ptr <= w_rd_ptr_inc;
            // Ready only when a free entry is guaranteed for next cycle's single push
            r_s_rdy <= (w_count_nxt < CNT_W'(DEPTH));
        end
    end

    cmn_reg_slice_store #(
        .PLD_TYPE (PLD_TYPE),
        .DEPTH    (DEPTH),
        .PTR_W    (PTR_W)
    ) u_store (
        .clk     (clk),
        .wr_en   (w_push & ~flush),
        .wr_ptr  (r_wr_ptr),
        .wr_data (bus.s_pld),
        .rd_ptr  (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    assign bus.s_rdy = r_s_rdy;
    assign bus.m_vld = w_m_vld;
    assign bus.m_pld = w_empty ? bus.s_pld : w_rd_data;
    assign bus.level = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cmn_reg_slice_backward_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmn_reg_slice_backward_n
// Description : Directed self-checking bench: three slice configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cmn_reg_slice_backward_n;

    typedef logic [7:0] pld_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    cmn_reg_slice_backward_n_if #(.PLD_TYPE(pld_t), .DEPTH(2)) ifa ();
    cmn_reg_slice_backward_n_if #(.PLD_TYPE(pld_t), .DEPTH(4)) ifb ();
    cmn_reg_slice_backward_n_if #(.PLD_TYPE(pld_t), .DEPTH(3)) ifc ();

    cmn_reg_slice_backward_n #(.PLD_TYPE(pld_t), .DEPTH(2), .BYPASS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifa));
    cmn_reg_slice_backward_n #(.PLD_TYPE(pld_t), .DEPTH(4), .BYPASS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifb));
    cmn_reg_slice_backward_n #(.PLD_TYPE(pld_t), .DEPTH(3), .BYPASS(0)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifc));

    int   n_cmp = 0;
    int   n_err = 0;
    int   sent;
    int   got;
    int   cyc;
    int   s_cyc;
    pld_t sb[$];
    int   sbc[$];
    pld_t exp_pld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifa.s_vld = 1'b1; ifa.s_pld = 8'h00; ifa.m_rdy = 1'b1;
        ifb.s_vld = 1'b1; ifb.s_pld = 8'h00; ifb.m_rdy = 1'b1;
        ifc.s_vld = 1'b1; ifc.s_pld = 8'h00; ifc.m_rdy = 1'b1;

        // Reset held 3 cycles with upstream valid asserted
        repeat (3) begin
            tick; #1;
            chk("rst_s_rdy", 32'(ifb.s_rdy), 32'd0);
            chk("rst_m_vld", 32'(ifb.m_vld), 32'd0);
            chk("rst_level", 32'(ifb.level), 32'd0);
        end
        tick;
        rst_n = 1'b1;
        ifa.s_vld = 1'b0; ifb.s_vld = 1'b0; ifc.s_vld = 1'b0;
        #1;
        chk("rel_s_rdy_early", 32'(ifb.s_rdy), 32'd0);
        tick; #1;
        chk("rel_s_rdy_a", 32'(ifa.s_rdy), 32'd1);
        chk("rel_s_rdy_b", 32'(ifb.s_rdy), 32'd1);
        chk("rel_s_rdy_c", 32'(ifc.s_rdy), 32'd1);

        // Full-rate zero-latency stream through the DEPTH=2 bypass slice
        for (int i = 0; i < 100; i++) begin
            ifa.s_vld = 1'b1;
            ifa.s_pld = pld_t'(i);
            #1;
            chk("a_stream_vld", 32'(ifa.m_vld), 32'd1);
            chk("a_stream_pld", 32'(ifa.m_pld), 32'(i));
            chk("a_stream_lvl", 32'(ifa.level), 32'd0);
            chk("a_stream_rdy", 32'(ifa.s_rdy), 32'd1);
            tick;
        end
        ifa.s_vld = 1'b0;

        // Backpressure on DEPTH=4: offer A0..A5 while downstream stalls
        sent = 0;
        ifb.m_rdy = 1'b0;
        for (int c = 0; c < 8; c++) begin
            ifb.s_vld = 1'b1;
            ifb.s_pld = pld_t'(8'hA0 + sent);
            #1;
            if (ifb.s_rdy) sent++;
            tick;
        end
        chk("b_bp_accepted", 32'(sent), 32'd4);
        chk("b_bp_level", 32'(ifb.level), 32'd4);
        chk("b_bp_s_rdy", 32'(ifb.s_rdy), 32'd0);
        chk("b_bp_m_vld", 32'(ifb.m_vld), 32'd1);
        chk("b_bp_head", 32'(ifb.m_pld), 32'hA0);

        got = 0;
        for (int c = 0; c < 14; c++) begin
            ifb.m_rdy = 1'b1;
            ifb.s_vld = (sent < 6);
            ifb.s_pld = pld_t'(8'hA0 + sent);
            #1;
            if (ifb.m_vld) begin
                chk("b_drain_pld", 32'(ifb.m_pld), 32'(8'hA0 + got));
                got++;
            end
            if (ifb.s_vld && ifb.s_rdy) sent++;
            tick;
        end
        chk("b_drain_count", 32'(got), 32'd6);
        chk("b_drain_level", 32'(ifb.level), 32'd0);
        chk("b_drain_idle", 32'(ifb.m_vld), 32'd0);

        // Flush at level 3 while 0x55 is accepted in the same cycle
        ifb.m_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifb.s_vld = 1'b1;
            ifb.s_pld = pld_t'(8'h10 + i);
            tick;
        end
        flush = 1'b1;
        ifb.s_pld = 8'h55;
        #1;
        chk("b_fl_level_pre", 32'(ifb.level), 32'd3);
        chk("b_fl_m_vld", 32'(ifb.m_vld), 32'd0);
        chk("b_fl_s_rdy_pre", 32'(ifb.s_rdy), 32'd1);
        tick;
        flush = 1'b0;
        ifb.s_vld = 1'b0;
        ifb.m_rdy = 1'b1;
        #1;
        chk("b_fl_level", 32'(ifb.level), 32'd0);
        chk("b_fl_s_rdy", 32'(ifb.s_rdy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("b_fl_no_55", 32'(ifb.m_vld), 32'd0);
            tick;
        end

        // Saturated random stream on DEPTH=4 against a FIFO scoreboard
        sent = 0;
        got  = 0;
        for (int c = 0; c < 40000 && got < 10000; c++) begin
            ifb.s_vld = (sent < 10000);
            ifb.s_pld = pld_t'(sent * 13);
            ifb.m_rdy = 1'($urandom_range(0, 1));
            #1;
            if (ifb.s_vld && ifb.s_rdy) begin
                sb.push_back(ifb.s_pld);
                sent++;
            end
            if (ifb.m_vld && ifb.m_rdy) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL b_rand_spurious observed=%0h expected=none", ifb.m_pld);
                end else begin
                    exp_pld = sb.pop_front();
                    chk("b_rand_pld", 32'(ifb.m_pld), 32'(exp_pld));
                    got++;
                end
            end
            chk("b_rand_lvl_max", 32'(ifb.level <= 3'd4), 32'd1);
            tick;
        end
        ifb.s_vld = 1'b0;
        chk("b_rand_count", 32'(got), 32'd10000);

        // Non-bypass DEPTH=3 slice: latency >= 1 and order across pointer wraps
        sent = 0;
        got  = 0;
        cyc  = 0;
        for (int c = 0; c < 200 && got < 20; c++) begin
            cyc++;
            ifc.s_vld = (sent < 20);
            ifc.s_pld = pld_t'(8'hC0 + sent);
            ifc.m_rdy = (c == 0) || ($urandom_range(0, 2) != 0);
            #1;
            if (c == 0)
                chk("c_no_bypass", 32'(ifc.m_vld), 32'd0);
            if (ifc.m_vld && ifc.m_rdy) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL c_spurious observed=%0h expected=none", ifc.m_pld);
                end else begin
                    exp_pld = sb.pop_front();
                    s_cyc   = sbc.pop_front();
                    chk("c_pld", 32'(ifc.m_pld), 32'(exp_pld));
                    chk("c_latency", 32'(cyc - s_cyc >= 1), 32'd1);
                    got++;
                end
            end
            if (ifc.s_vld && ifc.s_rdy) begin
                sb.push_back(ifc.s_pld);
                sbc.push_back(cyc);
                sent++;
            end
            tick;
        end
        ifc.s_vld = 1'b0;
        #1;
        chk("c_count", 32'(got), 32'd20);
        chk("c_level", 32'(ifc.level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
